mem_access_unit: RTL and testbench

Multi-cycle load/store unit that sits directly downstream of the ALU/shifter result path. It takes the ALU-computed byte address and the rD2 store operand, and performs one aligned bus transaction with a req/ack handshake. It returns sign- or zero-extended load data for writeback, or reports a misalignment or bus timeout fault.

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 215 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bus port bundle for mem_access_unit.
// master: the load/store unit (drives request, address, enables, write data).
// slave : the memory/bus side (returns single-cycle ack and read data).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: one aligned req/ack bus transaction per start,
// returning sign/zero-extended load data or a misalign/timeout fault.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, mem_we     begin access (IDLE only), 1 = store
//   funct3            access width/sign (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   alu_c, rD2        byte address, store operand
//   busy, done        state != IDLE, one-cycle completion pulse
//   rdata             extended load result, held until next successful load
//   misalign, timeout fault flags, valid with done
//   bus               mem_access_unit_if.master
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_c,
  input  logic [31:0] rD2,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        timeout,
  mem_access_unit_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              mis_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [7:0]        lane_b_c;
  logic [15:0]       lane_h_c;
  logic [31:0]       load_c;

  // Illegal width/alignment decode for the incoming request
  always_comb begin
    mis_c = 1'b0;
    unique case (funct3)
      3'b001, 3'b101: mis_c = alu_c[0];
      3'b010:         mis_c = (alu_c[1:0] != 2'b00);
      3'b011, 3'b110, 3'b111: mis_c = 1'b1;
      default:        mis_c = 1'b0;
    endcase
    if (mem_we && (funct3 == 3'b100 || funct3 == 3'b101)) mis_c = 1'b1;
  end

  // Byte enables and lane-replicated store data for the incoming request
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = rD2;
    unique case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << alu_c[1:0];
        wdata_c = {4{rD2[7:0]}};
      end
      2'b01: begin
        be_c    = alu_c[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{rD2[15:0]}};
      end
      2'b10:   be_c = 4'b1111;
      default: be_c = 4'b0000;
    endcase
  end

  // Load lane select and extension from the latched offset/width
  always_comb begin
    unique case (off_q)
      2'd0:    lane_b_c = bus.bus_rdata[7:0];
      2'd1:    lane_b_c = bus.bus_rdata[15:8];
      2'd2:    lane_b_c = bus.bus_rdata[23:16];
      default: lane_b_c = bus.bus_rdata[31:24];
    endcase
    lane_h_c = off_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    unique case (f3_q)
      3'b000:  load_c = {{24{lane_b_c[7]}}, lane_b_c};
      3'b100:  load_c = {24'h0, lane_b_c};
      3'b001:  load_c = {{16{lane_h_c[15]}}, lane_h_c};
      3'b101:  load_c = {16'h0, lane_h_c};
      default: load_c = bus.bus_rdata;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;
    bus_req_d   = 1'b0;
    bus_we_d    = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          we_d        = mem_we;
          f3_d        = funct3;
          off_d       = alu_c[1:0];
          bus_addr_d  = {alu_c[31:2], 2'b00};
          bus_be_d    = be_c;
          bus_wdata_d = wdata_c;
          if (mis_c) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            misalign_d = 1'b1;
          end else begin
            state_d   = S_REQ;
            cnt_d     = '0;
            bus_req_d = 1'b1;
            bus_we_d  = mem_we;
          end
        end
      end
      S_REQ: begin
        // Ack on the final allowed cycle still completes normally
        if (bus.bus_ack) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (!we_q) rdata_d = load_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          bus_req_d = 1'b1;
          bus_we_d  = we_q;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign misalign      = misalign_q;
  assign timeout       = timeout_q;
  assign rdata         = rdata_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// accesses against a behavioural model of the load/store rules.
module tb_mem_access_unit;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 5;
  localparam int          NEVER   = 1000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] alu_c;
  logic [31:0] rD2;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        timeout;

  mem_access_unit_if bus ();

  mem_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mem_we   (mem_we),
    .funct3   (funct3),
    .alu_c    (alu_c),
    .rD2      (rD2),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .misalign (misalign),
    .timeout  (timeout),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit model_mis(input bit we, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz, off, m;
    sz  = acc_size(f3);
    off = a % 4;
    off = off - (off % sz);
    m   = ((1 << sz) - 1) << off;
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (acc_size(f3))
      1:       return (d & 32'hFF) * 32'h0101_0101;
      2:       return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int unsigned off;
    off = a % 4;
    v   = rd >> (8 * off);
    case (acc_size(f3))
      1: begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2: begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  // ---------------- access driver ----------------
  // Entered and left at posedge+1. ack_at = 0-based REQ cycle carrying ack.
  task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int ack_at, input logic [31:0] rd_in,
                           input bit poke_busy);
    bit mis, acked;
    int unsigned req_cycles;
    mis = model_mis(we, f3, a);
    start = 1'b1; mem_we = we; funct3 = f3; alu_c = a; rD2 = d;
    @(posedge clk); #1;
    start = 1'b0;
    acked = 1'b0;
    req_cycles = 0;
    if (mis) begin
      check_eq("mis_done", 32'(done), 32'd1);
      check_eq("mis_flag", 32'(misalign), 32'd1);
      check_eq("mis_noreq", 32'(bus.bus_req), 32'd0);
    end else begin
      for (int k = 0; k < int'(TIMEOUT); k++) begin
        if (bus.bus_req !== 1'b1) break;
        req_cycles++;
        check_eq("req_addr", bus.bus_addr, a & 32'hFFFF_FFFC);
        check_eq("req_be", 32'(bus.bus_be), 32'(model_be(f3, a)));
        check_eq("req_we", 32'(bus.bus_we), 32'(we));
        if (we) check_eq("req_wdata", bus.bus_wdata, model_wdata(f3, d));
        check_eq("req_busy", 32'(busy), 32'd1);
        // A start during REQ must be ignored without disturbing the access
        if (poke_busy) begin
          start = 1'b1; mem_we = ~we; alu_c = $urandom; rD2 = $urandom;
        end
        bus.bus_ack   = (k == ack_at);
        bus.bus_rdata = (k == ack_at) ? rd_in : $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        bus.bus_ack = 1'b0;
        if (k == ack_at) begin acked = 1'b1; break; end
      end
      check_eq("req_cycles", req_cycles, acked ? 32'(ack_at + 1) : TIMEOUT);
      if (acked && !we) exp_rdata = model_load(f3, a, rd_in);
      check_eq("end_done", 32'(done), 32'd1);
      check_eq("end_timeout", 32'(timeout), acked ? 32'd0 : 32'd1);
      check_eq("end_misalign", 32'(misalign), 32'd0);
      check_eq("end_noreq", 32'(bus.bus_req), 32'd0);
    end
    check_eq("rdata", rdata, exp_rdata);
    // Start on the done cycle lands in DONE and must not be taken
    if (poke_busy) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("post_done", 32'(done), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_req", 32'(bus.bus_req), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_mis"}, 32'(misalign), 32'd0);
    check_eq({tag, "_to"}, 32'(timeout), 32'd0);
    check_eq({tag, "_req"}, 32'(bus.bus_req), 32'd0);
    check_eq({tag, "_we"}, 32'(bus.bus_we), 32'd0);
    check_eq({tag, "_addr"}, bus.bus_addr, 32'd0);
    check_eq({tag, "_be"}, 32'(bus.bus_be), 32'd0);
    check_eq({tag, "_wdata"}, bus.bus_wdata, 32'd0);
    check_eq({tag, "_rdata"}, rdata, 32'd0);
  endtask

  initial begin
    logic [2:0] f3_tab [8];
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd3};
    rst_n = 1'b0; start = 1'b0; mem_we = 1'b0; funct3 = 3'd0; alu_c = '0; rD2 = '0;
    bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_access(1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
    check_eq("lw_const", rdata, 32'hDEAD_BEEF);
    do_access(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF_FF00, 1'b0);
    check_eq("lb_const", rdata, 32'hFFFF_FF80);
    do_access(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF_FF00, 1'b0);
    check_eq("lbu_const", rdata, 32'h0000_0080);
    do_access(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 0, 32'h5555_5555, 1'b0);
    check_eq("sh_wdata_const", bus.bus_wdata, 32'hABCD_ABCD);
    check_eq("sh_be_const", 32'(bus.bus_be), 32'hC);
    check_eq("sh_rdata_kept", rdata, 32'h0000_0080);
    do_access(1'b0, 3'b010, 32'h6, 32'h0, 0, 32'h0, 1'b0);
    do_access(1'b1, 3'b100, 32'h40, 32'hFF, 0, 32'h0, 1'b0);
    do_access(1'b0, 3'b010, 32'h200, 32'h0, NEVER, 32'h0, 1'b0);
    check_eq("to_rdata_kept", rdata, 32'h0000_0080);
    do_access(1'b0, 3'b001, 32'h302, 32'h0, int'(TIMEOUT) - 1, 32'h9ABC_1234, 1'b0);
    check_eq("ack_last_const", rdata, 32'hFFFF_9ABC);
    do_access(1'b0, 3'b101, 32'h306, 32'h0, 3, 32'h9ABC_1234, 1'b1);

    // Reset during the second REQ cycle
    start = 1'b1; mem_we = 1'b0; funct3 = 3'b010; alu_c = 32'h400; rD2 = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreq");
    @(posedge clk); #1;
    check_eq("midreq_nodone", 32'(done), 32'd0);
    rst_n = 1'b1;
    exp_rdata = 32'h0;
    @(posedge clk); #1;
    do_access(1'b0, 3'b000, 32'h401, 32'h0, 0, 32'h0000_7F00, 1'b0);

    // Randomized accesses
    for (int i = 0; i < 150; i++) begin
      bit we;
      logic [2:0] f3;
      int ack_at;
      we = 1'($urandom_range(0, 1));
      f3 = f3_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 15) == 0) f3 = 3'(7 - $urandom_range(0, 1));
      ack_at = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT - 1));
      do_access(we, f3, $urandom, $urandom, ack_at, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
